// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_pipe_mc ALU.
//   - 4-bit opcode codes. Any wider opcode field must have its upper bits at zero.
//   - Bit positions inside the 4-bit Flags word.
//   - Encoding of the handshake FSM states.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_XNOR = 4'b1001;
    localparam logic [3:0] OP_EQU  = 4'b1010;
    localparam logic [3:0] OP_GRT  = 4'b1011;
    localparam logic [3:0] OP_LESS = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_SHL  = 4'b1110;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_DBZ   = 2;
    localparam int FLAG_ERR   = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        DIV_RUN = 1'b1
    } state_e;

endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: iterative restoring divider for unsigned operands.
// It produces one quotient bit per clock, starting with the MSB.
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   start               load dividend/divisor and begin (caller guarantees divisor != 0)
//   dividend, divisor   WIDTH-bit operands, sampled when start is high
//   done                high on the clock whose edge completes the last step
//   quotient, remainder the final values, valid while done is high
// The quotient and remainder outputs come straight from the step logic.
// This lets the caller register them on the same edge that retires the last bit,
// so the total latency is WIDTH clocks after the start edge.
module alu_div_iter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             run_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out the top while quotient bits shift in
    logic [WIDTH-1:0] div_q;
    logic [WIDTH:0]   trial;

    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]};
        if (trial >= {1'b0, div_q}) begin
            rem_d = WIDTH'(trial - {1'b0, div_q});
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= CNT_W'(WIDTH - 1);
            rem_q <= '0;
            quo_q <= dividend;
            div_q <= divisor;
        end else if (run_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done      = run_q && (cnt_q == '0);
    assign quotient  = quo_d;
    assign remainder = rem_d;

endmodule

// File: rtl/alu_pipe_mc.sv
// alu_pipe_mc: ALU with valid/ready request and result handshakes.
// Single-cycle ops finish in one clock. DIV with a nonzero divisor is multi-cycle.
// Ports:
//   CLK, RST             clock; synchronous active-high reset
//   A, B, ALU_FUN        operands and opcode, sampled when IN_Valid && IN_Ready
//   IN_Valid / IN_Ready  request handshake
//   ALU_OUT, Flags       registered result and {Err, DivByZero, Carry, Zero}
//   OUT_Valid/OUT_Ready  result handshake (the result is held until consumed)
//   Busy                 divider running
module alu_pipe_mc
    import alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FUN_WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [FUN_WIDTH-1:0] ALU_FUN,
    input  logic                 IN_Valid,
    output logic                 IN_Ready,
    output logic [2*WIDTH-1:0]   ALU_OUT,
    output logic [3:0]           Flags,
    output logic                 OUT_Valid,
    input  logic                 OUT_Ready,
    output logic                 Busy
);

    localparam int OUT_WIDTH = 2 * WIDTH;

    state_e                 state_q, state_d;
    logic                   out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]   alu_out_q, alu_out_d;
    logic [3:0]             flags_q, flags_d;

    logic                   op_ok;
    logic [3:0]             op;
    logic                   accept, div_start, write_sc;
    logic                   div_done;
    logic [WIDTH-1:0]       div_quo, div_rem;

    logic [WIDTH:0]         sum;
    logic [OUT_WIDTH-1:0]   prod;
    logic [OUT_WIDTH-1:0]   sc_res;
    logic                   sc_carry, sc_dbz, sc_err;

    // If the opcode field is wider than 4 bits, any set upper bit makes the code out of range.
    generate
        if (FUN_WIDTH > 4) begin : g_wide_fun
            assign op_ok = ~|ALU_FUN[FUN_WIDTH-1:4];
        end else begin : g_narrow_fun
            assign op_ok = 1'b1;
        end
    endgenerate
    assign op = ALU_FUN[3:0];

    assign IN_Ready  = (state_q == IDLE) && (!out_valid_q || OUT_Ready);
    assign accept    = IN_Valid && IN_Ready;
    assign div_start = accept && op_ok && (op == OP_DIV) && (B != '0);
    assign write_sc  = accept && !div_start;

    // Single-cycle datapath. Concatenation with zeros keeps each WIDTH-bit
    // sub-expression self-sized, so the results are zero-extended, not sign-extended.
    always_comb begin
        sum      = {1'b0, A} + {1'b0, B};
        prod     = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_dbz   = 1'b0;
        sc_err   = 1'b0;
        if (!op_ok) begin
            sc_err = 1'b1;
        end else begin
            case (op)
                OP_ADD:  begin sc_res = {{(WIDTH-1){1'b0}}, sum}; sc_carry = sum[WIDTH]; end
                OP_SUB:  begin sc_res = {{WIDTH{1'b0}}, (A - B)}; sc_carry = (A < B); end
                OP_MUL:  begin sc_res = prod; sc_carry = |prod[OUT_WIDTH-1:WIDTH]; end
                OP_DIV:  begin
                    // A nonzero divisor goes to the iterative path. Only the divide-by-zero result is formed here.
                    if (B == '0) begin
                        sc_res = {A, {WIDTH{1'b1}}};
                        sc_dbz = 1'b1;
                    end
                end
                OP_AND:  sc_res = {{WIDTH{1'b0}}, (A & B)};
                OP_OR:   sc_res = {{WIDTH{1'b0}}, (A | B)};
                OP_NAND: sc_res = {{WIDTH{1'b0}}, ~(A & B)};
                OP_NOR:  sc_res = {{WIDTH{1'b0}}, ~(A | B)};
                OP_XOR:  sc_res = {{WIDTH{1'b0}}, (A ^ B)};
                OP_XNOR: sc_res = {{WIDTH{1'b0}}, ~(A ^ B)};
                OP_EQU:  sc_res = (A == B) ? OUT_WIDTH'(1) : '0;
                OP_GRT:  sc_res = (A > B)  ? OUT_WIDTH'(2) : '0;
                OP_LESS: sc_res = (A < B)  ? OUT_WIDTH'(3) : '0;
                OP_SHR:  begin sc_res = {{WIDTH{1'b0}}, 1'b0, A[WIDTH-1:1]}; sc_carry = A[0]; end
                OP_SHL:  begin sc_res = {{WIDTH{1'b0}}, A[WIDTH-2:0], 1'b0}; sc_carry = A[WIDTH-1]; end
                default: sc_err = 1'b1;
            endcase
        end
    end

    alu_div_iter #(
        .WIDTH(WIDTH)
    ) u_div (
        .CLK      (CLK),
        .RST      (RST),
        .start    (div_start),
        .dividend (A),
        .divisor  (B),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        alu_out_d   = alu_out_q;
        flags_d     = flags_q;

        case (state_q)
            IDLE:    if (div_start) state_d = DIV_RUN;
            DIV_RUN: if (div_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (out_valid_q && OUT_Ready) begin
            out_valid_d = 1'b0;
        end
        // A new result written on the same edge as a consume keeps OUT_Valid high.
        // A divide can only complete when the slot is free, because it was accepted with the slot free.
        if (write_sc || div_done) begin
            out_valid_d = 1'b1;
            flags_d     = '0;
            if (div_done) begin
                alu_out_d = {div_rem, div_quo};
            end else begin
                alu_out_d           = sc_res;
                flags_d[FLAG_CARRY] = sc_carry;
                flags_d[FLAG_DBZ]   = sc_dbz;
                flags_d[FLAG_ERR]   = sc_err;
            end
            flags_d[FLAG_ZERO] = (alu_out_d == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            flags_q     <= flags_d;
        end
    end

    assign ALU_OUT   = alu_out_q;
    assign Flags     = flags_q;
    assign OUT_Valid = out_valid_q;
    assign Busy      = (state_q == DIV_RUN);

endmodule

// File: tb/tb_alu_pipe_mc.sv
module tb_alu_pipe_mc;

    localparam int W = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [W-1:0]  A, B;
    logic [3:0]    ALU_FUN;
    logic          IN_Valid, IN_Ready;
    logic [2*W-1:0] ALU_OUT;
    logic [3:0]    Flags;
    logic          OUT_Valid, OUT_Ready, Busy;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    // Behavioural reference state
    logic          m_valid     = 0;
    logic [15:0]   m_out       = 0;
    logic [3:0]    m_flags     = 0;
    int            m_div_left  = 0;
    logic [15:0]   m_div_res   = 0;
    logic [3:0]    m_div_flags = 0;

    alu_pipe_mc #(.WIDTH(W), .FUN_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .IN_Valid(IN_Valid), .IN_Ready(IN_Ready), .ALU_OUT(ALU_OUT),
        .Flags(Flags), .OUT_Valid(OUT_Valid), .OUT_Ready(OUT_Ready), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Results computed directly from the opcode table with plain integer arithmetic.
    function automatic void ref_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                                   output logic [15:0] r, output logic [3:0] fl, output bit mc);
        int ai = int'(a);
        int bi = int'(b);
        int v  = 0;
        bit c = 0, dz = 0, er = 0;
        mc = 0;
        case (f)
            4'd0:  begin v = ai + bi; c = (v > 255); end
            4'd1:  begin v = (ai - bi + 256) % 256; c = (ai < bi); end
            4'd2:  begin v = ai * bi; c = (v > 255); end
            4'd3:  begin
                if (bi == 0) begin v = ai * 256 + 255; dz = 1; end
                else begin v = (ai % bi) * 256 + (ai / bi); mc = 1; end
            end
            4'd4:  v = ai & bi;
            4'd5:  v = ai | bi;
            4'd6:  v = 255 - (ai & bi);
            4'd7:  v = 255 - (ai | bi);
            4'd8:  v = ai ^ bi;
            4'd9:  v = 255 - (ai ^ bi);
            4'd10: v = (ai == bi) ? 1 : 0;
            4'd11: v = (ai > bi) ? 2 : 0;
            4'd12: v = (ai < bi) ? 3 : 0;
            4'd13: begin v = ai / 2; c = ai % 2; end
            4'd14: begin v = (ai * 2) % 256; c = (ai >= 128); end
            default: begin v = 0; er = 1; end
        endcase
        r  = 16'(v);
        fl = {er, dz, c, (v == 0)};
    endfunction

    // Reference model, advanced on every rising edge
    always @(posedge CLK) begin
        automatic logic [15:0] r, no;
        automatic logic [3:0]  fl, nf;
        automatic bit          mc, rdy, acc, nv;
        automatic int          nleft;
        if (RST) begin
            m_valid    <= 0;
            m_out      <= 0;
            m_flags    <= 0;
            m_div_left <= 0;
        end else begin
            rdy   = (m_div_left == 0) && (!m_valid || OUT_Ready);
            acc   = IN_Valid && rdy;
            nv    = m_valid && !OUT_Ready;
            no    = m_out;
            nf    = m_flags;
            nleft = m_div_left;
            if (m_div_left != 0) begin
                nleft = m_div_left - 1;
                if (m_div_left == 1) begin nv = 1; no = m_div_res; nf = m_div_flags; end
            end
            if (acc) begin
                ref_op(A, B, ALU_FUN, r, fl, mc);
                $display("txn op=%0d a=%0d b=%0d result=%h flags=%b multicycle=%0d", ALU_FUN, A, B, r, fl, mc);
                if (mc) begin
                    nleft = W;
                    m_div_res   <= r;
                    m_div_flags <= fl;
                end else begin
                    nv = 1; no = r; nf = fl;
                end
            end
            m_valid    <= nv;
            m_out      <= no;
            m_flags    <= nf;
            m_div_left <= nleft;
        end
    end

    // Compare process: the DUT is checked against the model on every falling edge.
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("out_valid", 32'(OUT_Valid), 32'(m_valid));
            chk("busy",      32'(Busy),      32'(m_div_left != 0));
            chk("in_ready",  32'(IN_Ready),  32'((m_div_left == 0) && (!m_valid || OUT_Ready)));
            chk("alu_out",   32'(ALU_OUT),   32'(m_out));
            chk("flags",     32'(Flags),     32'(m_flags));
        end
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f, input logic v);
        A = a; B = b; ALU_FUN = f; IN_Valid = v;
    endtask

    task automatic next_cyc();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        RST = 1; OUT_Ready = 1;
        drive(0, 0, 0, 0);
        @(posedge CLK);
        #1 cmp_en = 1;
        @(posedge CLK);
        #2 RST = 0;

        // Reset state
        @(negedge CLK);
        chk("rst_alu_out", 32'(ALU_OUT), 32'h0);
        chk("rst_valid",   32'(OUT_Valid), 32'h0);
        chk("rst_busy",    32'(Busy), 32'h0);
        chk("rst_ready",   32'(IN_Ready), 32'h1);

        // ADD 200+100
        next_cyc(); drive(200, 100, 4'd0, 1);
        next_cyc(); drive(0, 0, 0, 0);
        @(negedge CLK);
        chk("add_out",   32'(ALU_OUT), 32'h012C);
        chk("add_model", 32'(m_out), 32'h012C);
        chk("add_flags", 32'(Flags), 32'b0010);
        chk("add_valid", 32'(OUT_Valid), 32'h1);
        @(negedge CLK);
        chk("add_consumed", 32'(OUT_Valid), 32'h0);

        // MUL 255*255 then SUB 5-5 back to back
        next_cyc(); drive(255, 255, 4'd2, 1);
        next_cyc(); drive(5, 5, 4'd1, 1);
        @(negedge CLK);
        chk("mul_out",   32'(ALU_OUT), 32'hFE01);
        chk("mul_flags", 32'(Flags), 32'b0010);
        next_cyc(); drive(0, 0, 0, 0);
        @(negedge CLK);
        chk("sub_out",   32'(ALU_OUT), 32'h0000);
        chk("sub_flags", 32'(Flags), 32'b0001);
        chk("sub_valid", 32'(OUT_Valid), 32'h1);

        // DIV 200/7: eight busy cycles, result on the ninth
        next_cyc(); drive(200, 7, 4'd3, 1);
        next_cyc(); drive(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("div_busy",    32'(Busy), 32'h1);
            chk("div_inready", 32'(IN_Ready), 32'h0);
        end
        @(negedge CLK);
        chk("div_out",   32'(ALU_OUT), 32'h041C);
        chk("div_model", 32'(m_out), 32'h041C);
        chk("div_valid", 32'(OUT_Valid), 32'h1);
        chk("div_idle",  32'(Busy), 32'h0);

        // DIV by zero, then invalid opcode
        next_cyc(); drive(5, 0, 4'd3, 1);
        next_cyc(); drive(1, 2, 4'd15, 1);
        @(negedge CLK);
        chk("dbz_out",   32'(ALU_OUT), 32'h05FF);
        chk("dbz_flags", 32'(Flags), 32'b0100);
        chk("dbz_busy",  32'(Busy), 32'h0);
        next_cyc(); drive(0, 0, 0, 0);
        @(negedge CLK);
        chk("err_out",   32'(ALU_OUT), 32'h0000);
        chk("err_flags", 32'(Flags), 32'b1001);

        // Backpressure: XOR result held while a pending ADD request is ignored
        next_cyc(); drive(8'hF0, 8'h3C, 4'd8, 1);
        next_cyc(); OUT_Ready = 0; drive(1, 1, 4'd0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_out",   32'(ALU_OUT), 32'h00CC);
            chk("bp_flags", 32'(Flags), 32'b0000);
            chk("bp_ready", 32'(IN_Ready), 32'h0);
            chk("bp_valid", 32'(OUT_Valid), 32'h1);
        end
        next_cyc(); OUT_Ready = 1;
        @(negedge CLK);
        chk("bp_release_ready", 32'(IN_Ready), 32'h1);
        next_cyc(); drive(0, 0, 0, 0);
        @(negedge CLK);
        chk("bp_next_out", 32'(ALU_OUT), 32'h0002);

        // Reset in the middle of a divide
        next_cyc(); drive(100, 3, 4'd3, 1);
        next_cyc(); drive(0, 0, 0, 0);
        repeat (3) @(posedge CLK);
        #2 RST = 1;
        next_cyc(); RST = 0;
        @(negedge CLK);
        chk("rstdiv_valid", 32'(OUT_Valid), 32'h0);
        chk("rstdiv_busy",  32'(Busy), 32'h0);
        chk("rstdiv_ready", 32'(IN_Ready), 32'h1);
        chk("rstdiv_out",   32'(ALU_OUT), 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            chk("rstdiv_noresult", 32'(OUT_Valid), 32'h0);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            next_cyc();
            RST       = ($urandom_range(0, 399) == 0);
            OUT_Ready = ($urandom_range(0, 9) < 7);
            IN_Valid  = ($urandom_range(0, 9) < 7);
            A         = 8'($urandom);
            B         = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            ALU_FUN   = ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom_range(0, 15));
        end
        next_cyc();
        RST = 0; OUT_Ready = 1; drive(0, 0, 0, 0);
        repeat (12) @(posedge CLK);
        @(negedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
